uart_rx_frame_decoder: RTL

- UART receive-side frame engine: oversamples the serial rx line, detects the start bit, shifts in LSB-first data, checks the optional odd/even parity bit and the stop bit, then presents the byte with error flags.
- Receive-path counterpart of the transmit parity/serializer logic; sits between the rx pad synchronizer domain (fixed clock) and the rx FIFO.
- Parity convention matches the transmitter: odd mode means the total count of 1s over the data bits plus the parity bit is odd; even mode means that count is even.

---
 rtl/uart_rx_frame_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame engine. The rx line is synchronized and oversampled.
// A falling edge starts a frame, and the start bit is confirmed at mid-bit.
// Data is shifted in LSB first. The optional parity bit and the stop bit
// are then checked. The byte and its error flags appear with a one-clk valid.
module uart_rx_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  rst_i,
  input  logic                  baud_tick_i,
  input  logic                  rx_i,
  input  logic                  parity_en_i,
  input  logic                  mode_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  xor_acc_q, xor_acc_d;
  logic                  par_en_q, par_en_d;
  logic                  mode_q, mode_d;
  logic                  perr_q, perr_d;
  logic                  start_pend_q, start_pend_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ferr_out_q, ferr_out_d;
  logic                  fall;

  assign fall = rx_prev_q & ~rx_s_q;

  // Next-state logic for the synchronizer, frame FSM, counters and output registers.
  always_comb begin
    // NOTE: every *_d gets a default so no path through the case infers a latch.
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    xor_acc_d    = xor_acc_q;
    par_en_d     = par_en_q;
    mode_d       = mode_q;
    perr_d       = perr_q;
    start_pend_d = start_pend_q;
    rx_meta_d    = rx_i;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    perr_out_d   = perr_out_q;
    ferr_out_d   = ferr_out_q;

    case (state_q)
      IDLE: begin
        start_pend_d = 1'b0;
        if (fall || start_pend_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          par_en_d   = parity_en_i;
          mode_d     = mode_i;
        end
      end
      START: if (baud_tick_i) begin
        if (tick_cnt_q == TICK_HALF) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          xor_acc_d  = 1'b0;
          state_d    = rx_s_q ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      DATA: if (baud_tick_i) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          xor_acc_d  = xor_acc_q ^ rx_s_q;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      PARITY: if (baud_tick_i) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          perr_d     = rx_s_q != (mode_q ? xor_acc_q : ~xor_acc_q);
          state_d    = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      STOP: if (baud_tick_i) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d   = '0;
          state_d      = IDLE;
          valid_d      = 1'b1;
          data_d       = shift_q;
          perr_out_d   = par_en_q & perr_q;
          ferr_out_d   = ~rx_s_q;
          // The edge detector moves on next clk, so an edge seen now must be remembered.
          start_pend_d = fall;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      state_d      = IDLE;
      tick_cnt_d   = '0;
      bit_cnt_d    = '0;
      shift_d      = '0;
      xor_acc_d    = 1'b0;
      par_en_d     = 1'b0;
      mode_d       = 1'b0;
      perr_d       = 1'b0;
      start_pend_d = 1'b0;
      rx_meta_d    = 1'b1;
      rx_s_d       = 1'b1;
      rx_prev_d    = 1'b1;
      data_d       = '0;
      valid_d      = 1'b0;
      perr_out_d   = 1'b0;
      ferr_out_d   = 1'b0;
    end
  end

  // State registers with asynchronous reset; the rx line flops reset to idle-high.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      xor_acc_q    <= 1'b0;
      par_en_q     <= 1'b0;
      mode_q       <= 1'b0;
      perr_q       <= 1'b0;
      start_pend_q <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_out_q   <= 1'b0;
      ferr_out_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values (synchronizer chain depends on it).
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      xor_acc_q    <= xor_acc_d;
      par_en_q     <= par_en_d;
      mode_q       <= mode_d;
      perr_q       <= perr_d;
      start_pend_q <= start_pend_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_out_q   <= perr_out_d;
      ferr_out_q   <= ferr_out_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign busy_o       = (state_q != IDLE);

endmodule
